// File: rtl/accumulator_param.sv
// accumulator_param
// -----------------------------------------------------------------------------
// Parametrised partial-product accumulator for the chunked multiplier datapath.
// A bank of LANES small CHUNK_W x CHUNK_W multipliers delivers unsigned partial
// products over BEATS = (OP_W/CHUNK_W)^2 / LANES beats. Each partial product is
// shifted into place and summed into a 2*OP_W accumulator. A single correction
// cycle then turns the unsigned product into a signed/unsigned one, and the
// result is offered on a valid/ready handshake to writeback.
//
// Optional feature macro: ACCUM_ABORT_EN (adds the abort input).
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   abort                   (ACCUM_ABORT_EN only) cancel operation, back to IDLE
//   start                   begin operation (sampled in IDLE only)
//   op_a, op_b              operands, captured on accepted start
//   signed_a, signed_b      operand signedness, captured on accepted start
//   pp_valid, pp_in         partial-product beat; lane l at [l*2*CHUNK_W +: 2*CHUNK_W]
//   pp_ready                beat accepted this cycle (ACCUM only)
//   beat_idx                index of the beat expected next (0 outside ACCUM)
//   busy                    operation in flight (state != IDLE)
//   result_valid, result_ready  product handshake
//   product_1, product_2    low / high half of the product
//   dbg_state               current FSM state (IDLE=0, ACCUM=1, CORRECT=2, DONE=3)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1. pp_ready and result_valid depend only on the FSM state, never on the
// partner's valid/ready, so there is no combinational path between the sides;
// the product stays stable while result_valid=1 and result_ready=0.
// -----------------------------------------------------------------------------
module accumulator_param #(
  parameter int OP_W    = 32,
  parameter int CHUNK_W = 8,
  parameter int LANES   = 8,
  localparam int K      = OP_W / CHUNK_W,
  localparam int BEATS  = (K * K) / LANES,
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int PP_W   = 2 * CHUNK_W,
  localparam int ACC_W  = 2 * OP_W
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef ACCUM_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  start,
  input  logic [OP_W-1:0]       op_a,
  input  logic [OP_W-1:0]       op_b,
  input  logic                  signed_a,
  input  logic                  signed_b,
  input  logic                  pp_valid,
  input  logic [LANES*PP_W-1:0] pp_in,
  output logic                  pp_ready,
  output logic [BIDX_W-1:0]     beat_idx,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [OP_W-1:0]       product_1,
  output logic [OP_W-1:0]       product_2,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    CORRECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [BIDX_W-1:0] beat_q, beat_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [OP_W-1:0]   p1_q, p1_d;
  logic [OP_W-1:0]   p2_q, p2_d;

  // Sum of all lanes of the current beat, each shifted into its place.
  // Global chunk index i = beat*LANES + lane selects row (chunk of B) = i / K
  // and col (chunk of A) = i % K; the product weight is 2^((row+col)*CHUNK_W).
  logic [ACC_W-1:0] beat_sum;

  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_sum = beat_sum +
        (ACC_W'(pp_in[l*PP_W +: PP_W]) <<
          ((((int'(beat_q) * LANES + l) / K) + ((int'(beat_q) * LANES + l) % K)) * CHUNK_W));
    end
  end

  // Signed correction: treating a negative operand as unsigned adds 2^OP_W
  // times the other operand; subtract that back out. The cross term that both
  // corrections would imply is a multiple of 2^(2*OP_W) and vanishes.
  logic [ACC_W-1:0] corr_a;
  logic [ACC_W-1:0] corr_b;
  logic [ACC_W-1:0] acc_fix;

  assign corr_a  = (sa_q && a_q[OP_W-1]) ? ACC_W'(b_q) : '0;
  assign corr_b  = (sb_q && b_q[OP_W-1]) ? ACC_W'(a_q) : '0;
  assign acc_fix = acc_q - ((corr_a + corr_b) << OP_W);

  logic last_beat;
  assign last_beat = (beat_q == BIDX_W'(BEATS - 1));

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    p1_d    = p1_q;
    p2_d    = p2_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          sa_d    = signed_a;
          sb_d    = signed_b;
          acc_d   = '0;
          beat_d  = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (pp_valid) begin
          acc_d = acc_q + beat_sum;
          if (last_beat) begin
            beat_d  = '0;
            state_d = CORRECT;
          end else begin
            beat_d = beat_q + BIDX_W'(1);
          end
        end
      end
      CORRECT: begin
        acc_d   = acc_fix;
        p1_d    = acc_fix[OP_W-1:0];
        p2_d    = acc_fix[ACC_W-1:OP_W];
        state_d = DONE;
      end
      DONE: begin
        // A start seen here is deliberately dropped; restart only from IDLE.
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef ACCUM_ABORT_EN
    // Abort beats everything else, including the DONE handshake, and leaves
    // the last presented product untouched.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      acc_d   = '0;
      beat_d  = '0;
      p1_d    = p1_q;
      p2_d    = p2_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      beat_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      p1_q    <= '0;
      p2_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
    end
  end

  assign pp_ready     = (state_q == ACCUM);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign beat_idx     = (state_q == ACCUM) ? beat_q : '0;
  assign product_1    = p1_q;
  assign product_2    = p2_q;
  assign dbg_state    = state_q;

endmodule
